// File: rtl/dmem_responder.sv
// Word-organised data memory slave for the CPU's DM_CS / DM_R / DM_W strobes.
// A request is accepted only in IDLE. It then waits a programmable number of
// cycles, executes against the RAM, and answers with a one-cycle ready pulse.
// addr_err accompanies ready when the request is misaligned or its strobes
// are inconsistent.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dm_cs,
  input  logic        dm_r,
  input  logic        dm_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        addr_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [AW+1:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_r;
  logic        lat_w;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          req_err;
  logic          exec;
  logic          mem_we;
  logic          unused_addr_bits;

  // Address bits above the RAM index only alias, so they are never stored.
  assign unused_addr_bits = ^addr[31:AW+2];

  assign idx     = lat_addr[AW+1:2];
  assign req_err = (lat_addr[1:0] != 2'b00) || (lat_r == lat_w);
  assign exec    = (state == S_WAIT) && (cnt == 4'd0);
  // A reset on the execute edge discards the pending write.
  assign mem_we  = rst_n && exec && !req_err && lat_w;

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= lat_wdata;
    end
  end

  // Request FSM: latch in IDLE, count wait states, execute, pulse ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      ready     <= 1'b0;
      addr_err  <= 1'b0;
      rdata     <= 32'd0;
      lat_addr  <= '0;
      lat_wdata <= 32'd0;
      lat_r     <= 1'b0;
      lat_w     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ready    <= 1'b0;
          addr_err <= 1'b0;
          if (dm_cs) begin
            lat_addr  <= addr[AW+1:0];
            lat_wdata <= wdata;
            lat_r     <= dm_r;
            lat_w     <= dm_w;
            cnt       <= WAIT_INIT;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state    <= S_DONE;
            ready    <= 1'b1;
            addr_err <= req_err;
            if (!req_err && lat_r) begin
              rdata <= mem[idx];
            end
          end
        end
        S_DONE: begin
          ready    <= 1'b0;
          addr_err <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized transactions,
// checked against a word-indexed reference memory kept in the bench.
module tb_dmem_responder;

  localparam int W      = 2;
  localparam int DEPTH  = 1024;
  localparam int W0     = 0;
  localparam int DEPTH0 = 16;

  logic        clk;
  logic        rst_n;

  logic        dm_cs, dm_r, dm_w;
  logic [31:0] addr, wdata, rdata;
  logic        ready, addr_err;

  logic        cs0, r0, w0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ready0, err0;

  int assert_count = 0;
  int fail_count   = 0;

  logic [31:0] mem_model [int];
  int          written_q [$];
  logic [31:0] exp_rdata;

  logic [31:0] mem0 [DEPTH0];
  int          wq0 [$];
  logic [31:0] exp0_rdata;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .addr_err(addr_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH0), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst_n(rst_n), .dm_cs(cs0), .dm_r(r0), .dm_w(w0),
    .addr(addr0), .wdata(wdata0), .rdata(rdata0), .ready(ready0), .addr_err(err0)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drive garbage on the request inputs; the DUT must ignore it outside IDLE.
  task automatic scramble();
    dm_cs = 1'($urandom);
    dm_r  = 1'($urandom);
    dm_w  = 1'($urandom);
    addr  = $urandom;
    wdata = $urandom;
  endtask

  // One complete request on the main instance, checked cycle by cycle.
  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input string tag);
    logic        err;
    int unsigned i;
    err = (a[1:0] != 2'b00) || (r == w);
    i   = (a >> 2) % DEPTH;
    @(negedge clk);
    dm_cs = 1'b1; dm_r = r; dm_w = w; addr = a; wdata = d;
    @(posedge clk); #1;
    checkOutput({tag, "_accept_ready"}, {31'b0, ready}, 32'd0);
    scramble();
    for (int k = 1; k <= W; k++) begin
      @(posedge clk); #1;
      checkOutput({tag, "_wait_ready"}, {31'b0, ready}, 32'd0);
      checkOutput({tag, "_wait_err"}, {31'b0, addr_err}, 32'd0);
      checkOutput({tag, "_wait_rdata"}, rdata, exp_rdata);
      scramble();
    end
    @(posedge clk); #1;
    if (!err && w) begin
      if (!mem_model.exists(int'(i))) written_q.push_back(int'(i));
      mem_model[int'(i)] = d;
    end
    if (!err && r) exp_rdata = mem_model[int'(i)];
    checkOutput({tag, "_done_ready"}, {31'b0, ready}, 32'd1);
    checkOutput({tag, "_done_err"}, {31'b0, addr_err}, {31'b0, err});
    checkOutput({tag, "_done_rdata"}, rdata, exp_rdata);
    scramble();
    @(posedge clk); #1;
    checkOutput({tag, "_idle_ready"}, {31'b0, ready}, 32'd0);
    checkOutput({tag, "_idle_err"}, {31'b0, addr_err}, 32'd0);
    checkOutput({tag, "_idle_rdata"}, rdata, exp_rdata);
    dm_cs = 1'b0;
  endtask

  initial begin
    int          op, idx, k;
    logic        rr, ww;
    logic [31:0] a, d, up;
    logic        p_r, p_w;
    logic [31:0] p_a, p_d;

    rst_n = 1'b0;
    dm_cs = 1'b0; dm_r = 1'b0; dm_w = 1'b0; addr = 32'd0; wdata = 32'd0;
    cs0 = 1'b0; r0 = 1'b0; w0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
    exp_rdata = 32'd0;
    exp0_rdata = 32'd0;
    p_r = 1'b0; p_w = 1'b0; p_a = 32'd0; p_d = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", {31'b0, ready}, 32'd0);
    checkOutput("reset_err", {31'b0, addr_err}, 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset0_ready", {31'b0, ready0}, 32'd0);
    checkOutput("reset0_rdata", rdata0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed scenarios");
    applyStimulus(1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, "wr_10");
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, "rd_10");
    checkOutput("rd_10_const", rdata, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 32'h12345678, "wr_misaligned");
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, "rd_10_after_mis");
    checkOutput("rd_10_after_mis_const", rdata, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b1, 32'h0000_0010, 32'h0BADF00D, "both_strobes");
    checkOutput("both_strobes_rdata_const", rdata, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 32'h0000_0010, 32'h0BADF00D, "no_strobes");
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, "rd_10_after_bad");
    checkOutput("rd_10_after_bad_const", rdata, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b1, 32'h0000_1010, 32'hCAFEF00D, "wr_alias");
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, "rd_alias");
    checkOutput("rd_alias_const", rdata, 32'hCAFEF00D);
    applyStimulus(1'b0, 1'b1, 32'h0000_0020, 32'hA5A5A5A5, "wr_20");

    // Write to 0x20, then reset on the edge where cnt is 1.
    @(negedge clk);
    dm_cs = 1'b1; dm_r = 1'b0; dm_w = 1'b1; addr = 32'h20; wdata = 32'h11111111;
    @(posedge clk); #1;
    dm_cs = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_rdata = 32'd0;
    checkOutput("midrst_ready", {31'b0, ready}, 32'd0);
    checkOutput("midrst_err", {31'b0, addr_err}, 32'd0);
    checkOutput("midrst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      checkOutput("midrst_no_pulse", {31'b0, ready}, 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0, "rd_20_after_rst");
    checkOutput("rd_20_after_rst_const", rdata, 32'hA5A5A5A5);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      d  = $urandom;
      up = $urandom;
      idx = $urandom_range(0, 31);
      rr = 1'b0;
      ww = 1'b1;
      if (op >= 4 && op <= 6 && written_q.size() > 0) begin
        idx = written_q[$urandom_range(0, written_q.size() - 1)];
        rr = 1'b1;
        ww = 1'b0;
      end
      a = {up[31:12], 10'(idx), 2'b00};
      if (op == 7) begin
        rr = 1'($urandom);
        ww = ~rr;
        a[1:0] = 2'($urandom_range(1, 3));
      end else if (op == 8) begin
        rr = 1'b1; ww = 1'b1;
      end else if (op == 9) begin
        rr = 1'b0; ww = 1'b0;
      end
      applyStimulus(rr, ww, a, d, "rand");
    end

    // Zero-wait instance with dm_cs held high: accepts every third edge.
    $display("[TB] zero-wait back-to-back requests");
    for (k = 0; k < 48; k++) begin
      @(negedge clk);
      cs0 = 1'b1;
      if (k % 3 == 0) begin
        up = $urandom;
        if (k < 24) begin
          r0 = 1'b0; w0 = 1'b1;
          idx = $urandom_range(0, DEPTH0 - 1);
        end else begin
          r0 = 1'b1; w0 = 1'b0;
          idx = wq0[$urandom_range(0, wq0.size() - 1)];
        end
        addr0  = {up[31:6], 4'(idx), 2'b00};
        wdata0 = $urandom;
        p_r = r0; p_w = w0; p_a = addr0; p_d = wdata0;
      end else begin
        r0 = 1'($urandom); w0 = 1'($urandom);
        addr0 = $urandom; wdata0 = $urandom;
      end
      @(posedge clk); #1;
      if (k % 3 == 1) begin
        idx = int'((p_a >> 2) % DEPTH0);
        if (p_w) begin
          mem0[idx] = p_d;
          if (!(idx inside {wq0})) wq0.push_back(idx);
        end
        if (p_r) exp0_rdata = mem0[idx];
      end
      checkOutput("b2b_ready", {31'b0, ready0}, {31'b0, (k % 3 == 1)});
      checkOutput("b2b_err", {31'b0, err0}, 32'd0);
      checkOutput("b2b_rdata", rdata0, exp0_rdata);
    end
    cs0 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
